// File: rtl/bcd_tick_counter.sv
// Multi-digit BCD event counter stepped by a programmable prescaler, with
// up/down counting, parallel load, a wrap pulse and a rotating digit scan output.
module bcd_tick_counter #(
  parameter int                   DIV_WIDTH = 24,
  parameter logic [DIV_WIDTH-1:0] MAX_COUNT = 24'd10_000_000,
  parameter int                   DIGITS    = 4,
  parameter int                   SCAN_DIV  = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic [7:0]            period,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tick,
  output logic                  wrap,
  output logic [DIGITS-1:0]     scan_sel,
  output logic [3:0]            scan_bcd,
  output logic [7:0]            prescale_lsb
);

  localparam int CW  = 4 * DIGITS;
  localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DIV_WIDTH-1:0] pre_q, pre_d, compare;
  logic [CW-1:0]        count_q, count_d, load_sat, count_step;
  logic                 tick_q, tick_d, wrap_q, wrap_d;
  logic [DIGITS-1:0]    scan_sel_q, scan_sel_d;
  logic [SCW-1:0]       scan_cnt_q, scan_cnt_d;
  logic                 pre_hit, carry_out;

  always_comb begin
    compare = (period == 8'd0) ? MAX_COUNT : DIV_WIDTH'({period, 10'b0});
  end

  // Out-of-range load digits saturate so the count never holds a non-BCD digit.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_load_sat
      assign load_sat[4*gi +: 4] = (load_value[4*gi +: 4] > 4'd9) ? 4'd9 : load_value[4*gi +: 4];
    end
  endgenerate

  // Ripple carry/borrow through the digits; c ends as the carry out of the top digit.
  always_comb begin : ripple
    logic       c;
    logic [3:0] digit;
    count_step = count_q;
    c          = 1'b1;
    digit      = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = count_q[4*i +: 4];
      if (c) begin
        if (up) begin
          if (digit == 4'd9) begin
            count_step[4*i +: 4] = 4'd0;
          end else begin
            count_step[4*i +: 4] = digit + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (digit == 4'd0) begin
            count_step[4*i +: 4] = 4'd9;
          end else begin
            count_step[4*i +: 4] = digit - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    carry_out = c;
  end

  always_comb begin
    pre_d   = pre_q;
    count_d = count_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    pre_hit = (pre_q == compare);
    if (load) begin
      count_d = load_sat;
      pre_d   = '0;
    end else if (run) begin
      if (pre_hit) begin
        pre_d   = '0;
        count_d = count_step;
        tick_d  = 1'b1;
        wrap_d  = carry_out;
      end else begin
        pre_d = pre_q + DIV_WIDTH'(1);
      end
    end
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + SCW'(1);
    scan_sel_d = scan_sel_q;
    if (scan_cnt_q == SCW'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      scan_sel_d = (scan_sel_q << 1) | (scan_sel_q >> (DIGITS - 1));
    end
  end

  always_comb begin
    scan_bcd = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_sel_q[i]) scan_bcd = count_q[4*i +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q      <= '0;
      count_q    <= '0;
      tick_q     <= 1'b0;
      wrap_q     <= 1'b0;
      scan_sel_q <= DIGITS'(1);
      scan_cnt_q <= '0;
    end else begin
      pre_q      <= pre_d;
      count_q    <= count_d;
      tick_q     <= tick_d;
      wrap_q     <= wrap_d;
      scan_sel_q <= scan_sel_d;
      scan_cnt_q <= scan_cnt_d;
    end
  end

  assign count        = count_q;
  assign tick         = tick_q;
  assign wrap         = wrap_q;
  assign scan_sel     = scan_sel_q;
  assign prescale_lsb = 8'(pre_q);

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Scoreboard bench for bcd_tick_counter: stimulus queues expected {count, wrap}
// per step, a monitor pops and compares on every tick.
module tb_bcd_tick_counter;

  logic        clk = 1'b0;
  logic        reset, run, up, load;
  logic [15:0] load_value;
  logic [7:0]  period;
  logic [15:0] count;
  logic        tick, wrap;
  logic [3:0]  scan_sel;
  logic [3:0]  scan_bcd;
  logic [7:0]  prescale_lsb;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] count;
    logic        wrap;
  } exp_t;
  exp_t sb[$];

  bcd_tick_counter #(
    .DIV_WIDTH(24),
    .MAX_COUNT(24'd20),
    .DIGITS(4),
    .SCAN_DIV(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .run(run),
    .up(up),
    .load(load),
    .load_value(load_value),
    .period(period),
    .count(count),
    .tick(tick),
    .wrap(wrap),
    .scan_sel(scan_sel),
    .scan_bcd(scan_bcd),
    .prescale_lsb(prescale_lsb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  // Monitor: every tick must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (tick) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_tick actual count=%h required no tick", count);
        end else begin
          e = sb.pop_front();
          if (count !== e.count || wrap !== e.wrap) begin
            errors++;
            $display("FAIL step actual count=%h wrap=%b required count=%h wrap=%b",
                     count, wrap, e.count, e.wrap);
          end else begin
            $display("ok   step count=%h wrap=%b", count, wrap);
          end
        end
      end else if (wrap) begin
        checks++;
        errors++;
        $display("FAIL wrap_without_tick actual wrap=1 required wrap=0");
      end
    end
  end

  // Waits for the next tick; n is the number of edges waited.
  task automatic wait_tick(output int n);
    n = 0;
    while (n < 3000) begin
      @(posedge clk);
      #1;
      n++;
      if (tick) return;
    end
    chk("tick_timeout", 32'(n), 32'(0));
  endtask

  task automatic do_load(input logic [15:0] v);
    load       = 1'b1;
    load_value = v;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  logic [15:0] exp_cnt;
  logic [3:0]  digit_tab [4];

  initial begin
    int n;
    reset = 1'b1; run = 1'b0; up = 1'b1; load = 1'b0;
    load_value = 16'h0000; period = 8'd1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_wrap", 32'(wrap), 32'h0);
    chk("rst_scan_sel", 32'(scan_sel), 32'h1);
    chk("rst_scan_bcd", 32'(scan_bcd), 32'h0);
    chk("rst_prescale", 32'(prescale_lsb), 32'h0);

    // Count up 10 steps with compare 1024
    reset = 1'b0; run = 1'b1;
    exp_cnt = 16'h0001;
    for (int i = 0; i < 10; i++) begin
      sb.push_back('{count: exp_cnt, wrap: 1'b0});
      exp_cnt = (i == 8) ? 16'h0010 : exp_cnt + 16'h1;
      wait_tick(n);
      chk("up_interval", 32'(n), 32'd1025);
    end
    chk("up_ten", 32'(count), 32'h0010);

    // Up wrap from 9998
    do_load(16'h9998);
    chk("load_9998", 32'(count), 32'h9998);
    sb.push_back('{count: 16'h9999, wrap: 1'b0});
    sb.push_back('{count: 16'h0000, wrap: 1'b1});
    wait_tick(n);
    chk("wrapup_interval", 32'(n), 32'd1025);
    wait_tick(n);
    @(posedge clk);
    #1;
    chk("wrap_one_cycle", 32'(wrap), 32'h0);

    // Down borrow from 0000
    up = 1'b0;
    do_load(16'h0000);
    sb.push_back('{count: 16'h9999, wrap: 1'b1});
    sb.push_back('{count: 16'h9998, wrap: 1'b0});
    wait_tick(n);
    wait_tick(n);
    chk("down_interval", 32'(n), 32'd1025);

    // Load coincident with pre == compare, with saturated digits
    up = 1'b1;
    do_load(16'h0000);
    repeat (1024) @(posedge clk);
    #1;
    do_load(16'h4A7C);
    chk("load_sat", 32'(count), 32'h4979);
    chk("load_no_tick", 32'(tick), 32'h0);
    chk("load_pre_clr", 32'(prescale_lsb), 32'h0);
    sb.push_back('{count: 16'h4980, wrap: 1'b0});
    wait_tick(n);
    chk("after_load_interval", 32'(n), 32'd1025);

    // Hold mid-period for 5000 cycles
    repeat (500) @(posedge clk);
    #1;
    run = 1'b0;
    repeat (5000) @(posedge clk);
    #1;
    chk("hold_count", 32'(count), 32'h4980);
    chk("hold_prescale", 32'(prescale_lsb), 32'hF4);
    run = 1'b1;
    sb.push_back('{count: 16'h4981, wrap: 1'b0});
    wait_tick(n);
    chk("resume_interval", 32'(n), 32'd525);

    // run dropped exactly while pre == compare: step deferred
    repeat (1024) @(posedge clk);
    #1;
    run = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("deferred_count", 32'(count), 32'h4981);
    run = 1'b1;
    sb.push_back('{count: 16'h4982, wrap: 1'b0});
    wait_tick(n);
    chk("deferred_interval", 32'(n), 32'd1);

    // Scan rotation with period 0 (compare = MAX_COUNT = 20)
    period = 8'd0; run = 1'b0; reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst2_count", 32'(count), 32'h0);
    do_load(16'h1234);
    chk("load_1234", 32'(count), 32'h1234);
    digit_tab[0] = 4'd4; digit_tab[1] = 4'd3; digit_tab[2] = 4'd2; digit_tab[3] = 4'd1;
    for (int k = 1; k < 20; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      chk("scan_sel", 32'(scan_sel), 32'(4'b0001 << ((k / 4) % 4)));
      chk("scan_bcd", 32'(scan_bcd), 32'(digit_tab[(k / 4) % 4]));
    end
    run = 1'b1;
    sb.push_back('{count: 16'h1235, wrap: 1'b0});
    wait_tick(n);
    chk("max_count_interval", 32'(n), 32'd21);

    // Reset mid-slot
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_scan_sel", 32'(scan_sel), 32'h1);
    chk("midrst_count", 32'(count), 32'h0);
    reset = 1'b0; run = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("sb_drain", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
